// File: rtl/scan_chain_controller.sv
// Scan-chain access sequencer: serial load, functional capture and serial unload
// with scan-enable settle gaps and valid/ready start/result handshakes.
module scan_chain_controller #(
  parameter int CHAIN_LENGTH   = 64,
  parameter int CNT_WIDTH      = 7,
  parameter int CAPTURE_CYCLES = 1,
  parameter int SE_SETTLE      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [1:0]              start_mode,
  input  logic [CHAIN_LENGTH-1:0] load_data,
  input  logic                    abort,
  output logic                    scan_in,
  input  logic                    scan_out,
  output logic                    scan_en,
  output logic                    capture_en,
  output logic                    clk_gate_en,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [CHAIN_LENGTH-1:0] result_data,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_SETTLE1 = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SETTLE2 = 3'd4,
    ST_UNLOAD  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam logic [1:0] MODE_SHIFT   = 2'b00;
  localparam logic [1:0] MODE_FULL    = 2'b01;
  localparam logic [1:0] MODE_CAPTURE = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SHIFT_LAST   = CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SE_SETTLE - 1);
  localparam logic [CNT_WIDTH-1:0] CAPTURE_LAST = CNT_WIDTH'(CAPTURE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic [CHAIN_LENGTH-1:0] shreg_q, shreg_d;
  logic [CHAIN_LENGTH-1:0] result_data_q, result_data_d;
  logic                    scan_in_q, scan_in_d;
  logic                    scan_en_q, scan_en_d;
  logic                    capture_en_q, capture_en_d;
  logic                    clk_gate_en_q, clk_gate_en_d;
  logic                    start_ready_q, start_ready_d;
  logic                    result_valid_q, result_valid_d;
  logic                    busy_q, busy_d;

  logic start_fire;
  logic result_fire;
  logic phase_last;

  assign start_fire  = start_valid & start_ready_q;
  assign result_fire = result_valid_q & result_ready;
  assign phase_last  = (cnt_q == CNT_ZERO);

  // Phase sequencing: next state, phase down-counter and latched mode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start_fire) begin
          mode_d = (start_mode == MODE_RSVD) ? MODE_FULL : start_mode;
          if (start_mode == MODE_CAPTURE) begin
            state_d = ST_SETTLE1;
            cnt_d   = SETTLE_LAST;
          end else begin
            state_d = ST_SHIFT;
            cnt_d   = SHIFT_LAST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (phase_last) begin
          if (mode_q == MODE_SHIFT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETTLE1;
            cnt_d   = SETTLE_LAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SETTLE1: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (phase_last) begin
          state_d = ST_CAPTURE;
          cnt_d   = CAPTURE_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (phase_last) begin
          if (mode_q == MODE_CAPTURE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETTLE2;
            cnt_d   = SETTLE_LAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SETTLE2: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (phase_last) begin
          state_d = ST_UNLOAD;
          cnt_d   = SHIFT_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_UNLOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (phase_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (result_fire) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Scan control outputs are decoded from the upcoming state so they register in step with it
  always_comb begin
    scan_en_d     = 1'b0;
    capture_en_d  = 1'b0;
    clk_gate_en_d = 1'b0;
    case (state_d)
      ST_SHIFT, ST_UNLOAD: begin
        scan_en_d     = 1'b1;
        clk_gate_en_d = 1'b1;
      end
      ST_SETTLE2: begin
        scan_en_d = 1'b1;
      end
      ST_CAPTURE: begin
        capture_en_d  = 1'b1;
        clk_gate_en_d = 1'b1;
      end
      default: begin
        scan_en_d     = 1'b0;
        capture_en_d  = 1'b0;
        clk_gate_en_d = 1'b0;
      end
    endcase
    busy_d        = (state_d != ST_IDLE);
    start_ready_d = (state_d == ST_IDLE);
  end

  // Serial datapath: pattern shifts out of the LSB while scan_out enters at the MSB
  always_comb begin
    shreg_d   = shreg_q;
    scan_in_d = 1'b0;
    if (start_fire) begin
      shreg_d   = load_data;
      scan_in_d = (start_mode != MODE_CAPTURE) & load_data[0];
    end else if ((state_q == ST_SHIFT) || (state_q == ST_UNLOAD)) begin
      shreg_d   = {scan_out, shreg_q[CHAIN_LENGTH-1:1]};
      scan_in_d = (state_d == ST_SHIFT) ? shreg_q[1] : 1'b0;
    end else begin
      shreg_d   = shreg_q;
      scan_in_d = 1'b0;
    end
    // Result is published one cycle after DONE entry and then held until accepted
    result_valid_d = (state_q == ST_DONE) && !result_fire;
    if ((state_q == ST_DONE) && !result_valid_q && (mode_q != MODE_CAPTURE)) begin
      result_data_d = shreg_q;
    end else begin
      result_data_d = result_data_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= CNT_ZERO;
      mode_q         <= MODE_SHIFT;
      shreg_q        <= {CHAIN_LENGTH{1'b0}};
      result_data_q  <= {CHAIN_LENGTH{1'b0}};
      scan_in_q      <= 1'b0;
      scan_en_q      <= 1'b0;
      capture_en_q   <= 1'b0;
      clk_gate_en_q  <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      shreg_q        <= shreg_d;
      result_data_q  <= result_data_d;
      scan_in_q      <= scan_in_d;
      scan_en_q      <= scan_en_d;
      capture_en_q   <= capture_en_d;
      clk_gate_en_q  <= clk_gate_en_d;
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign scan_in      = scan_in_q;
  assign scan_en      = scan_en_q;
  assign capture_en   = capture_en_q;
  assign clk_gate_en  = clk_gate_en_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: an 8-bit scan chain model with capture value 8'hC3
// and a phase-level reference model of expected results, latencies and control waveforms.
module tb_scan_chain_controller;

  localparam int N    = 8;
  localparam int S    = 1;
  localparam int C    = 1;
  localparam int UNL0 = N + 2*S + C;
  localparam logic [7:0] CAP_VAL = 8'hC3;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [1:0] start_mode;
  logic [7:0] load_data;
  logic       abort;
  logic       scan_in;
  logic       scan_out;
  logic       scan_en;
  logic       capture_en;
  logic       clk_gate_en;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] result_data;
  logic       busy;

  logic [7:0] chain_q;
  logic       preload_en;
  logic [7:0] preload_val;
  logic [7:0] m_chain;
  logic [7:0] m_result;
  int         n_cmp;
  int         n_bad;

  scan_chain_controller #(
    .CHAIN_LENGTH  (N),
    .CNT_WIDTH     (4),
    .CAPTURE_CYCLES(C),
    .SE_SETTLE     (S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_mode  (start_mode),
    .load_data   (load_data),
    .abort       (abort),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .scan_en     (scan_en),
    .capture_en  (capture_en),
    .clk_gate_en (clk_gate_en),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data (result_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scan chain clocked by the gated clock: shift toward the LSB, or capture a fixed word
  always @(posedge clk) begin
    if (preload_en) chain_q <= preload_val;
    else if (clk_gate_en && scan_en) chain_q <= {scan_in, chain_q[7:1]};
    else if (clk_gate_en && capture_en) chain_q <= CAP_VAL;
  end
  assign scan_out = chain_q[0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {scan_en, capture_en, clk_gate_en} for cycle idx after the start handshake
  function automatic logic [2:0] exp_ctl(input logic [1:0] md, input int idx);
    int p;
    p = idx;
    if (md == 2'b00) return (p < N) ? 3'b101 : 3'b000;
    if (md == 2'b10) begin
      if (p < S) return 3'b000;
      p -= S;
      return (p < C) ? 3'b011 : 3'b000;
    end
    if (p < N) return 3'b101;
    p -= N;
    if (p < S) return 3'b000;
    p -= S;
    if (p < C) return 3'b011;
    p -= C;
    if (p < S) return 3'b100;
    p -= S;
    return (p < N) ? 3'b101 : 3'b000;
  endfunction

  task automatic preload(input logic [7:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    @(posedge clk); #1;
    preload_en  = 1'b0;
    m_chain     = v;
  endtask

  task automatic run_op(input logic [1:0] mode, input logic [7:0] data, input int abort_idx, input bit hold);
    logic [1:0] em;
    logic [7:0] exp_res;
    logic [7:0] sin_seq;
    int lat, bad_ctl, exp_lat, k, late_valid;
    bit done, aborted;
    em      = (mode == 2'b11) ? 2'b01 : mode;
    exp_lat = (em == 2'b00) ? N + 1 : (em == 2'b10) ? S + C + 1 : 2*N + 2*S + C + 1;
    check("start_ready_before_op", start_ready, 1'b1);
    start_valid = 1'b1;
    start_mode  = mode;
    load_data   = data;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0; bad_ctl = 0; sin_seq = 8'h00; done = 1'b0; aborted = 1'b0;
    while (!done && !aborted && lat < 100) begin
      if (result_valid) begin
        done = 1'b1;
      end else begin
        if ({scan_en, capture_en, clk_gate_en} !== exp_ctl(em, lat)) bad_ctl++;
        if (em != 2'b10 && lat < N) sin_seq[lat] = scan_in;
        if (em == 2'b01 && lat >= UNL0 && lat < UNL0 + N && scan_in !== 1'b0) bad_ctl++;
        if (lat == abort_idx) abort = 1'b1;
        @(posedge clk); #1;
        lat++;
        if (abort) begin
          abort   = 1'b0;
          aborted = 1'b1;
        end
      end
    end
    check("ctl_waveform_bad_cycles", bad_ctl, 0);
    if (em != 2'b10) check("scan_in_sequence", sin_seq, data);
    if (aborted) begin
      check("abort_ctl_drop", {scan_en, capture_en, clk_gate_en}, 3'b000);
      check("abort_busy", busy, 1'b0);
      check("abort_start_ready", start_ready, 1'b1);
      late_valid = 0;
      repeat (3) begin
        if (result_valid) late_valid++;
        @(posedge clk); #1;
      end
      check("abort_no_result", late_valid, 0);
      check("abort_result_unchanged", result_data, m_result);
      k = abort_idx - UNL0 + 1;
      m_chain = CAP_VAL >> k;
      check("abort_chain", chain_q, m_chain);
      return;
    end
    check("result_timeout", done, 1'b1);
    check("latency", lat, exp_lat);
    case (em)
      2'b00:   begin exp_res = m_chain;  m_chain = data;    end
      2'b01:   begin exp_res = CAP_VAL;  m_chain = 8'h00;   end
      default: begin exp_res = m_result; m_chain = CAP_VAL; end
    endcase
    m_result = exp_res;
    check("result_data", result_data, exp_res);
    check("chain_contents", chain_q, m_chain);
    if (!hold) begin
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check("result_valid_cleared", result_valid, 1'b0);
      check("start_ready_after_result", start_ready, 1'b1);
    end
  endtask

  task automatic finish_pending(input logic [7:0] exp_res, input int exp_wait);
    int w;
    w = 0;
    while (!result_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("pending_result_valid", result_valid, 1'b1);
    check("pending_latency", w, exp_wait);
    check("pending_result_data", result_data, exp_res);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] rmode;
    logic [7:0] rdata;
    int         rab;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start_valid = 1'b0; start_mode = 2'b00; load_data = 8'h00;
    abort = 1'b0; result_ready = 1'b0; preload_en = 1'b0; preload_val = 8'h00;
    m_result = 8'h00;
    preload(8'h3C);
    @(posedge clk); #1;
    check("rst_start_ready", start_ready, 1'b1);
    check("rst_ctl", {scan_en, capture_en, clk_gate_en, scan_in}, 4'b0000);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result_data", result_data, 8'h00);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 8'hA5, -1, 1'b0);          // shift-only, chain preloaded 3C
    run_op(2'b01, 8'hFF, -1, 1'b0);          // full sequence, captures C3
    run_op(2'b10, 8'h5A, -1, 1'b0);          // capture-only, result held
    run_op(2'b01, 8'h77, UNL0 + 3, 1'b0);    // abort in UNLOAD cycle 4
    run_op(2'b00, 8'h96, -1, 1'b0);

    // Result back-pressure; start and abort presented while DONE must be ignored
    run_op(2'b00, 8'h3A, -1, 1'b1);
    start_valid = 1'b1; start_mode = 2'b00; load_data = 8'hE1; abort = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_result_valid", result_valid, 1'b1);
      check("hold_result_data", result_data, m_result);
      check("hold_start_ready", start_ready, 1'b0);
    end
    abort = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("hs_result_valid", result_valid, 1'b0);
    check("hs_start_ready", start_ready, 1'b1);
    check("hs_busy", busy, 1'b0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("restart_busy", busy, 1'b1);
    check("restart_start_ready", start_ready, 1'b0);
    finish_pending(m_chain, N + 1);
    m_result = m_chain;
    m_chain  = 8'hE1;

    for (int i = 0; i < 8; i++) begin
      rmode = 2'($urandom_range(0, 3));
      rdata = 8'($urandom);
      rab   = -1;
      if (rmode[0] && !rmode[1] || rmode == 2'b11) begin
        if ($urandom_range(0, 2) == 0) rab = UNL0 + int'($urandom_range(0, N - 1));
      end
      run_op(rmode, rdata, rab, 1'b0);
    end

    // Asynchronous reset in the middle of SHIFT
    start_valid = 1'b1; start_mode = 2'b00; load_data = 8'h5B;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_scan_en", scan_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_scan_en", scan_en, 1'b0);
    check("async_rst_gate", clk_gate_en, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_start_ready", start_ready, 1'b1);
    check("async_rst_result_data", result_data, 8'h00);
    #2 rst_n = 1'b1;
    m_result = 8'h00;
    @(posedge clk); #1;
    preload(8'h55);
    run_op(2'b00, 8'h81, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_chain_controller.md
Name: scan_chain_controller

Overview:
- Sequences scan-chain test access for the PIFO datapath: serial load, functional capture, serial unload.
- Drives scan enable, capture enable and the clock-gate enable that qualifies the scan clock.
- Sits between the testbench or host test port and the scan-instrumented DUT.
- Start and result use valid/ready handshakes. The block owns all shift/capture ordering and scan-enable settle gaps.

Parameters:
- CHAIN_LENGTH, 64, scan-chain bit count (>=2).
- CNT_WIDTH, 7, shift counter width; must be >= clog2(CHAIN_LENGTH+1).
- CAPTURE_CYCLES, 1, functional-clock cycles in CAPTURE (>=1).
- SE_SETTLE, 1, dead cycles (clock gated off) around every scan_en change (>=1).

Ports:
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operation request
- start_ready  output  1  high only in IDLE
- start_mode  input  2  00 shift-only, 01 shift-capture-unload, 10 capture-only, 11 reserved (treated as 01)
- load_data  input  CHAIN_LENGTH  pattern; sampled on the start handshake
- abort  input  1  synchronous cancel
- scan_in  output  1  serial data to the chain (registered)
- scan_out  input  1  serial data from the chain
- scan_en  output  1  chain in shift mode
- capture_en  output  1  functional capture cycle
- clk_gate_en  output  1  enables the gated scan clock this cycle
- result_valid  output  1  result_data available
- result_ready  input  1  consumer accepts result
- result_data  output  CHAIN_LENGTH  unloaded chain contents
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0 except start_ready=1.
  - result_data cleared; internal shift register and counters cleared.
  - Reset mid-operation takes effect immediately; no result is produced.
- States: IDLE, SHIFT, SETTLE1, CAPTURE, SETTLE2, UNLOAD, DONE.
- IDLE: start_ready=1. On start_valid&start_ready, latch load_data and mode.
  - Mode 00/01 -> SHIFT; mode 10 -> SETTLE1.
- SHIFT: exactly CHAIN_LENGTH cycles with scan_en=1, clk_gate_en=1.
  - scan_in = load_data bit k in cycle k (LSB first).
  - scan_out is sampled every cycle into a right-shifting register (insert at MSB), so sample k lands in bit k after the final cycle.
  - Exit: mode 00 -> DONE; mode 01 -> SETTLE1.
- SETTLE1: SE_SETTLE cycles with scan_en=0, clk_gate_en=0, capture_en=0; then CAPTURE.
- CAPTURE: CAPTURE_CYCLES cycles with scan_en=0, capture_en=1, clk_gate_en=1.
  - Exit: mode 10 -> DONE; mode 01 -> SETTLE2.
- SETTLE2: SE_SETTLE cycles with scan_en=1, clk_gate_en=0; then UNLOAD.
- UNLOAD: CHAIN_LENGTH cycles with scan_en=1, clk_gate_en=1, scan_in=0; scan_out sampled as in SHIFT.
- DONE: scan_en=0, clk_gate_en=0, result_valid=1.
  - result_data = shift register (mode 00/01); for mode 10 it holds its previous value.
  - result_valid and result_data stay stable until result_ready; the handshake cycle returns to IDLE.
  - start_ready is 0 in DONE, so a new start cannot be accepted before the result is consumed.
- Latency, start handshake to result_valid:
  - mode 00: CHAIN_LENGTH+1 cycles.
  - mode 10: SE_SETTLE+CAPTURE_CYCLES+1 cycles.
  - mode 01: 2*CHAIN_LENGTH+2*SE_SETTLE+CAPTURE_CYCLES+1 cycles.
- Abort, sampled high in SHIFT/SETTLE/CAPTURE/UNLOAD:
  - Next state is IDLE; scan_en, clk_gate_en and capture_en drop the next cycle.
  - result_valid is never asserted; result_data is unchanged.
  - Abort in IDLE or DONE is ignored.
  - Abort and the final cycle of a phase together: abort wins.
- Counter: CNT_WIDTH-bit down-counter, loaded on each phase entry; the phase ends when the count reaches 0. No wrap past 0.
- Glitch-free requirement:
  - clk_gate_en is never 1 in the same cycle that scan_en changes value.
  - scan_en and capture_en are never both 1.
- All outputs are registered.

Test Plan (CHAIN_LENGTH=8, SE_SETTLE=1, CAPTURE_CYCLES=1; bench models the chain as an 8-bit shift register with a capture input of 8'hC3):
- Reset then mode 00, load_data=8'hA5, chain preloaded with 8'h3C -> scan_in sequence 1,0,1,0,0,1,0,1; result_valid 9 cycles after the handshake; result_data=8'h3C; chain holds 8'hA5.
- Mode 01, load_data=8'hFF -> result_valid after 20 cycles; result_data=8'hC3; capture_en high exactly 1 cycle; clk_gate_en low during both settle cycles.
- Mode 10 -> capture_en pulse after 1 settle cycle; result_valid after 3 cycles; result_data unchanged from the prior value.
- Abort asserted in UNLOAD cycle 4 of mode 01 -> IDLE next cycle; result_valid stays 0; start_ready=1; the next mode 00 completes normally.
- result_ready held low 5 cycles in DONE with start_valid=1 -> result stable; start not accepted until one cycle after the result handshake.
- rst_n pulsed low mid-SHIFT (async, between clock edges) -> scan_en, clk_gate_en and busy fall immediately; start_ready=1; result_data=0.
